// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the control bundle for the RV32 five-stage pipeline
// control unit.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'b00,
    A_PC   = 2'b01,
    A_ZERO = 2'b10
  } a_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef struct packed {
    logic      alu_src;
    a_sel_e    a_sel;
    alu_ctrl_e alu_ctrl;
    logic      branch;
    logic      jl;
    logic      jlr;
    logic      mem_read;
    logic      mem_write;
    logic [2:0] f3;
    logic      reg_write;
    wb_sel_e   wb_sel;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  // {alt, f3} -> ALU function; alt selects sub/sra.
  function automatic alu_ctrl_e alu_decode(input logic alt, input logic [2:0] f3);
    alu_ctrl_e op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: opcode/f3/f7 to control bundle, register
// usage flags and illegal-opcode detection.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter bit EN_ITYPE = 1'b1,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic         i_valid,
  input  logic [6:0]   i_opcode,
  input  logic [2:0]   i_f3,
  input  logic [6:0]   i_f7,
  output ctrl_bundle_t o_ctrl,
  output logic         o_uses_rs1,
  output logic         o_uses_rs2,
  output logic         o_illegal
);

  ctrl_bundle_t w_ctrl;
  logic         w_known;
  logic         w_uses_rs1;
  logic         w_uses_rs2;
  logic         w_unused_f7;

  assign w_unused_f7 = ^{i_f7[6], i_f7[4:0]};

  always_comb begin
    w_ctrl     = CTRL_BUBBLE;
    w_known    = 1'b1;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (i_opcode)
      OP_R: begin
        w_ctrl.alu_ctrl  = alu_decode(i_f7[5], i_f3);
        w_ctrl.reg_write = 1'b1;
        w_uses_rs1       = 1'b1;
        w_uses_rs2       = 1'b1;
      end
      OP_IMM: begin
        if (EN_ITYPE) begin
          // f7 only distinguishes srai from srli; addi has no subtract form
          w_ctrl.alu_ctrl  = alu_decode((i_f3 == 3'b101) && i_f7[5], i_f3);
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.reg_write = 1'b1;
          w_uses_rs1       = 1'b1;
        end else begin
          w_known = 1'b0;
        end
      end
      OP_LOAD: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.f3        = i_f3;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_sel    = WB_MEM;
        w_uses_rs1       = 1'b1;
      end
      OP_STORE: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.f3        = i_f3;
        w_uses_rs1       = 1'b1;
        w_uses_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        w_ctrl.alu_ctrl = ALU_SUB;
        w_ctrl.branch   = 1'b1;
        w_uses_rs1      = 1'b1;
        w_uses_rs2      = 1'b1;
      end
      OP_JAL: begin
        w_ctrl.a_sel     = A_PC;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.jl        = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_sel    = WB_PC4;
      end
      OP_JALR: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.jlr       = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_sel    = WB_PC4;
        w_uses_rs1       = 1'b1;
      end
      OP_LUI: begin
        if (EN_UPPER) begin
          w_ctrl.a_sel     = A_ZERO;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.reg_write = 1'b1;
        end else begin
          w_known = 1'b0;
        end
      end
      OP_AUIPC: begin
        if (EN_UPPER) begin
          w_ctrl.a_sel     = A_PC;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.reg_write = 1'b1;
        end else begin
          w_known = 1'b0;
        end
      end
      default: w_known = 1'b0;
    endcase
  end

  assign o_ctrl     = (i_valid && w_known) ? w_ctrl : CTRL_BUBBLE;
  assign o_uses_rs1 = i_valid && w_known && w_uses_rs1;
  assign o_uses_rs2 = i_valid && w_known && w_uses_rs2;
  assign o_illegal  = i_valid && !w_known;

endmodule

// File: rtl/pipe_control.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, load-use/RAW hazard stall, redirect flush and EX forwarding.
module pipe_control
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RF_ADDR_W = 5,
  parameter bit          EN_ITYPE  = 1'b1,
  parameter bit          EN_UPPER  = 1'b1,
  parameter bit          EN_FWD    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [6:0]           opcode,
  input  logic [2:0]           f3,
  input  logic [6:0]           f7,
  input  logic [RF_ADDR_W-1:0] rs1,
  input  logic [RF_ADDR_W-1:0] rs2,
  input  logic [RF_ADDR_W-1:0] rd,
  input  logic                 ex_redirect,
  output logic                 stall_if,
  output logic                 flush_id,
  output logic                 ex_alu_src,
  output logic [1:0]           ex_a_sel,
  output logic [3:0]           ex_alu_ctrl,
  output logic                 ex_branch,
  output logic                 ex_jl,
  output logic                 ex_jlr,
  output logic [1:0]           ex_fwd_a,
  output logic [1:0]           ex_fwd_b,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [2:0]           mem_f3,
  output logic                 wb_reg_write,
  output logic [1:0]           wb_sel,
  output logic [RF_ADDR_W-1:0] wb_rd,
  output logic                 illegal
);

  ctrl_bundle_t         w_id_ctrl;
  ctrl_bundle_t         w_id_bundle;
  logic                 w_uses_rs1;
  logic                 w_uses_rs2;
  logic                 w_id_illegal;
  logic [RF_ADDR_W-1:0] w_id_rd;
  logic [RF_ADDR_W-1:0] w_id_rs1;
  logic [RF_ADDR_W-1:0] w_id_rs2;

  ctrl_bundle_t         r_ex;
  logic [RF_ADDR_W-1:0] r_ex_rd;
  logic [RF_ADDR_W-1:0] r_ex_rs1;
  logic [RF_ADDR_W-1:0] r_ex_rs2;
  logic                 r_ex_illegal;

  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [2:0]           r_mem_f3;
  logic                 r_mem_reg_write;
  wb_sel_e              r_mem_wb_sel;
  logic [RF_ADDR_W-1:0] r_mem_rd;

  logic                 r_wb_reg_write;
  wb_sel_e              r_wb_sel;
  logic [RF_ADDR_W-1:0] r_wb_rd;

  logic                 w_ex_hit;
  logic                 w_mem_hit;
  logic                 w_hazard;
  logic                 w_ex_bubble;

  ctrl_decode #(
    .EN_ITYPE(EN_ITYPE),
    .EN_UPPER(EN_UPPER)
  ) u_decode (
    .i_valid    (id_valid),
    .i_opcode   (opcode),
    .i_f3       (f3),
    .i_f7       (f7),
    .o_ctrl     (w_id_ctrl),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_illegal  (w_id_illegal)
  );

  // Unused source fields and non-written rd are carried as x0, so every
  // hazard/forward compare below reduces to "index nonzero and equal".
  always_comb begin
    w_id_bundle           = w_id_ctrl;
    w_id_bundle.reg_write = w_id_ctrl.reg_write && (rd != '0);
    w_id_rd               = w_id_bundle.reg_write ? rd : '0;
    w_id_rs1              = w_uses_rs1 ? rs1 : '0;
    w_id_rs2              = w_uses_rs2 ? rs2 : '0;
  end

  assign w_ex_hit  = (r_ex_rd != '0) && ((w_id_rs1 == r_ex_rd) || (w_id_rs2 == r_ex_rd));
  assign w_mem_hit = (r_mem_rd != '0) && ((w_id_rs1 == r_mem_rd) || (w_id_rs2 == r_mem_rd));
  assign w_hazard  = EN_FWD ? (r_ex.mem_read && w_ex_hit) : (w_ex_hit || w_mem_hit);

  assign w_ex_bubble = w_hazard || ex_redirect;
  assign stall_if    = w_hazard && !ex_redirect;
  assign flush_id    = ex_redirect && rst_n;

  function automatic fwd_e fwd_sel(
    input logic [RF_ADDR_W-1:0] src,
    input logic                 mem_we,
    input logic [RF_ADDR_W-1:0] mem_dst,
    input logic                 wb_we,
    input logic [RF_ADDR_W-1:0] wb_dst
  );
    fwd_e sel;
    if (!EN_FWD)
      sel = FWD_RF;
    else if (mem_we && (mem_dst != '0) && (mem_dst == src))
      sel = FWD_MEM;
    else if (wb_we && (wb_dst != '0) && (wb_dst == src))
      sel = FWD_WB;
    else
      sel = FWD_RF;
    return sel;
  endfunction

  assign ex_fwd_a = fwd_sel(r_ex_rs1, r_mem_reg_write, r_mem_rd, r_wb_reg_write, r_wb_rd);
  assign ex_fwd_b = fwd_sel(r_ex_rs2, r_mem_reg_write, r_mem_rd, r_wb_reg_write, r_wb_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex            <= CTRL_BUBBLE;
      r_ex_rd         <= '0;
      r_ex_rs1        <= '0;
      r_ex_rs2        <= '0;
      r_ex_illegal    <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_f3        <= '0;
      r_mem_reg_write <= 1'b0;
      r_mem_wb_sel    <= WB_ALU;
      r_mem_rd        <= '0;
      r_wb_reg_write  <= 1'b0;
      r_wb_sel        <= WB_ALU;
      r_wb_rd         <= '0;
    end else begin
      r_ex            <= w_ex_bubble ? CTRL_BUBBLE : w_id_bundle;
      r_ex_rd         <= w_ex_bubble ? '0 : w_id_rd;
      r_ex_rs1        <= w_ex_bubble ? '0 : w_id_rs1;
      r_ex_rs2        <= w_ex_bubble ? '0 : w_id_rs2;
      r_ex_illegal    <= !w_ex_bubble && w_id_illegal;
      r_mem_read      <= r_ex.mem_read;
      r_mem_write     <= r_ex.mem_write;
      r_mem_f3        <= r_ex.f3;
      r_mem_reg_write <= r_ex.reg_write;
      r_mem_wb_sel    <= r_ex.wb_sel;
      r_mem_rd        <= r_ex_rd;
      r_wb_reg_write  <= r_mem_reg_write;
      r_wb_sel        <= r_mem_wb_sel;
      r_wb_rd         <= r_mem_rd;
    end
  end

  assign ex_alu_src   = r_ex.alu_src;
  assign ex_a_sel     = r_ex.a_sel;
  assign ex_alu_ctrl  = r_ex.alu_ctrl;
  assign ex_branch    = r_ex.branch;
  assign ex_jl        = r_ex.jl;
  assign ex_jlr       = r_ex.jlr;
  assign illegal      = r_ex_illegal;
  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign mem_f3       = r_mem_f3;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_sel       = r_wb_sel;
  assign wb_rd        = r_wb_rd;

endmodule

// File: tb/tb_pipe_control.sv
// Randomized self-checking bench: instance 0 has all options enabled,
// instance 1 has I-type, upper-immediate and forwarding disabled.
module tb_pipe_control;

  typedef struct {
    bit       v;
    bit [6:0] op;
    bit [2:0] f3;
    bit [6:0] f7;
    bit [4:0] rs1, rs2, rd;
    bit       redir;
  } instr_t;

  // Expected contents of one pipeline slot.
  typedef struct packed {
    bit       src;
    bit [1:0] asel;
    bit [3:0] alu;
    bit       br, jl, jlr, ld, st;
    bit [2:0] f3;
    bit       regw;
    bit [1:0] wbsel;
    bit [4:0] rd, rs1, rs2;
    bit       ill;
  } mrec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       id_valid[2];
  logic [6:0] opcode[2];
  logic [2:0] f3[2];
  logic [6:0] f7[2];
  logic [4:0] rs1[2], rs2[2], rd[2];
  logic       ex_redirect[2];
  logic       stall_if[2], flush_id[2], ex_alu_src[2];
  logic [1:0] ex_a_sel[2];
  logic [3:0] ex_alu_ctrl[2];
  logic       ex_branch[2], ex_jl[2], ex_jlr[2];
  logic [1:0] ex_fwd_a[2], ex_fwd_b[2];
  logic       mem_read[2], mem_write[2];
  logic [2:0] mem_f3[2];
  logic       wb_reg_write[2];
  logic [1:0] wb_sel[2];
  logic [4:0] wb_rd[2];
  logic       illegal[2];

  pipe_control #(.RF_ADDR_W(5), .EN_ITYPE(1'b1), .EN_UPPER(1'b1), .EN_FWD(1'b1)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid[0]), .opcode(opcode[0]), .f3(f3[0]), .f7(f7[0]),
    .rs1(rs1[0]), .rs2(rs2[0]), .rd(rd[0]), .ex_redirect(ex_redirect[0]),
    .stall_if(stall_if[0]), .flush_id(flush_id[0]), .ex_alu_src(ex_alu_src[0]), .ex_a_sel(ex_a_sel[0]),
    .ex_alu_ctrl(ex_alu_ctrl[0]), .ex_branch(ex_branch[0]), .ex_jl(ex_jl[0]), .ex_jlr(ex_jlr[0]),
    .ex_fwd_a(ex_fwd_a[0]), .ex_fwd_b(ex_fwd_b[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_f3(mem_f3[0]), .wb_reg_write(wb_reg_write[0]), .wb_sel(wb_sel[0]), .wb_rd(wb_rd[0]),
    .illegal(illegal[0]));

  pipe_control #(.RF_ADDR_W(5), .EN_ITYPE(1'b0), .EN_UPPER(1'b0), .EN_FWD(1'b0)) u_dut_min (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid[1]), .opcode(opcode[1]), .f3(f3[1]), .f7(f7[1]),
    .rs1(rs1[1]), .rs2(rs2[1]), .rd(rd[1]), .ex_redirect(ex_redirect[1]),
    .stall_if(stall_if[1]), .flush_id(flush_id[1]), .ex_alu_src(ex_alu_src[1]), .ex_a_sel(ex_a_sel[1]),
    .ex_alu_ctrl(ex_alu_ctrl[1]), .ex_branch(ex_branch[1]), .ex_jl(ex_jl[1]), .ex_jlr(ex_jlr[1]),
    .ex_fwd_a(ex_fwd_a[1]), .ex_fwd_b(ex_fwd_b[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_f3(mem_f3[1]), .wb_reg_write(wb_reg_write[1]), .wb_sel(wb_sel[1]), .wb_rd(wb_rd[1]),
    .illegal(illegal[1]));

  int     n_checks = 0;
  int     n_fail   = 0;
  int     stall_cnt[2], flush_cnt[2], ill_cnt[2], wbw_cnt[2];
  mrec_t  m_ex[2], m_mem[2], m_wb[2];
  instr_t cur[2];
  bit     adv[2];
  bit     rand_mode = 1'b0;
  instr_t q0[$];
  instr_t q1[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit en(input int d);
    return d == 0;
  endfunction

  function automatic bit [3:0] alu_of(input bit alt, input bit [2:0] fn);
    case (fn)
      3'd0: return alt ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return alt ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic mrec_t model_decode(input instr_t in, input bit opt);
    mrec_t r;
    bit writes, u1, u2, ok;
    r = '0; writes = 0; u1 = 0; u2 = 0; ok = 1;
    case (in.op)
      7'h33: begin r.alu = alu_of(in.f7[5], in.f3); writes = 1; u1 = 1; u2 = 1; end
      7'h13: if (opt) begin
               r.alu = alu_of(in.f3 == 3'd5 && in.f7[5], in.f3); r.src = 1; writes = 1; u1 = 1;
             end else ok = 0;
      7'h03: begin r.src = 1; r.ld = 1; r.f3 = in.f3; writes = 1; r.wbsel = 2'd1; u1 = 1; end
      7'h23: begin r.src = 1; r.st = 1; r.f3 = in.f3; u1 = 1; u2 = 1; end
      7'h63: begin r.alu = 4'd1; r.br = 1; u1 = 1; u2 = 1; end
      7'h6f: begin r.asel = 2'd1; r.src = 1; r.jl = 1; writes = 1; r.wbsel = 2'd2; end
      7'h67: begin r.src = 1; r.jlr = 1; writes = 1; r.wbsel = 2'd2; u1 = 1; end
      7'h37: if (opt) begin r.asel = 2'd2; r.src = 1; writes = 1; end else ok = 0;
      7'h17: if (opt) begin r.asel = 2'd1; r.src = 1; writes = 1; end else ok = 0;
      default: ok = 0;
    endcase
    if (!in.v || !ok) begin
      r = '0;
      r.ill = in.v && !ok;
      return r;
    end
    r.regw = writes && (in.rd != 0);
    r.rd   = r.regw ? in.rd : 5'd0;
    r.rs1  = u1 ? in.rs1 : 5'd0;
    r.rs2  = u2 ? in.rs2 : 5'd0;
    return r;
  endfunction

  function automatic bit dep(input mrec_t older, input mrec_t id);
    return older.regw && older.rd != 0 && (id.rs1 == older.rd || id.rs2 == older.rd);
  endfunction

  function automatic bit m_hazard(input int d, input mrec_t id);
    if (en(d)) return m_ex[d].ld && dep(m_ex[d], id);
    return dep(m_ex[d], id) || dep(m_mem[d], id);
  endfunction

  function automatic bit [1:0] m_fwd(input int d, input bit [4:0] src);
    if (!en(d)) return 2'b00;
    if (m_mem[d].regw && m_mem[d].rd != 0 && m_mem[d].rd == src) return 2'b10;
    if (m_wb[d].regw && m_wb[d].rd != 0 && m_wb[d].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic instr_t mk(input bit [6:0] op, input bit [4:0] d_rd, input bit [4:0] a,
                                input bit [4:0] b, input bit [2:0] fn3, input bit [6:0] fn7,
                                input bit rdr);
    instr_t t;
    t.v = 1; t.op = op; t.rd = d_rd; t.rs1 = a; t.rs2 = b; t.f3 = fn3; t.f7 = fn7; t.redir = rdr;
    return t;
  endfunction

  function automatic instr_t idle();
    instr_t t;
    t = '{default: 0};
    return t;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t t;
    bit [6:0] op;
    case ($urandom_range(0, 10))
      0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23; 4: op = 7'h63;
      5: op = 7'h6f; 6: op = 7'h67; 7: op = 7'h37; 8: op = 7'h17; 9: op = 7'h00;
      default: op = 7'h7f;
    endcase
    t = mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
           $urandom_range(0, 9) == 0);
    t.v = $urandom_range(0, 9) != 0;
    return t;
  endfunction

  function automatic instr_t next_instr(input int d);
    if (d == 0 && q0.size() > 0) return q0.pop_front();
    if (d == 1 && q1.size() > 0) return q1.pop_front();
    return rand_mode ? rnd_instr() : idle();
  endfunction

  task automatic push(input instr_t t);
    q0.push_back(t);
    q1.push_back(t);
  endtask

  function automatic logic [31:0] all_out(input int d);
    return {2'b00, stall_if[d], flush_id[d], ex_alu_src[d], ex_a_sel[d], ex_alu_ctrl[d], ex_branch[d],
            ex_jl[d], ex_jlr[d], ex_fwd_a[d], ex_fwd_b[d], mem_read[d], mem_write[d], mem_f3[d],
            wb_reg_write[d], wb_sel[d], wb_rd[d], illegal[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ex[d] = '0; m_mem[d] = '0; m_wb[d] = '0; adv[d] = 1; cur[d] = idle();
    end
    q0.delete(); q1.delete();
  endtask

  task automatic apply(input int d);
    id_valid[d] = cur[d].v; opcode[d] = cur[d].op; f3[d] = cur[d].f3; f7[d] = cur[d].f7;
    rs1[d] = cur[d].rs1; rs2[d] = cur[d].rs2; rd[d] = cur[d].rd; ex_redirect[d] = cur[d].redir;
  endtask

  task automatic clr_cnt();
    for (int d = 0; d < 2; d++) begin
      stall_cnt[d] = 0; flush_cnt[d] = 0; ill_cnt[d] = 0; wbw_cnt[d] = 0;
    end
  endtask

  // One cycle: starts 1 time unit after a rising edge, checks at the falling edge.
  task automatic step();
    mrec_t idr[2];
    bit    haz[2];
    for (int d = 0; d < 2; d++) begin
      if (adv[d]) cur[d] = next_instr(d);
      apply(d);
    end
    #4;
    for (int d = 0; d < 2; d++) begin
      idr[d] = model_decode(cur[d], en(d));
      haz[d] = m_hazard(d, idr[d]);
      chk($sformatf("d%0d.stall_flush", d), {stall_if[d], flush_id[d]},
          {haz[d] && !cur[d].redir, cur[d].redir});
      chk($sformatf("d%0d.fwd", d), {ex_fwd_a[d], ex_fwd_b[d]},
          {m_fwd(d, m_ex[d].rs1), m_fwd(d, m_ex[d].rs2)});
      chk($sformatf("d%0d.ex_ctrl", d),
          {ex_alu_src[d], ex_a_sel[d], ex_alu_ctrl[d], ex_branch[d], ex_jl[d], ex_jlr[d]},
          {m_ex[d].src, m_ex[d].asel, m_ex[d].alu, m_ex[d].br, m_ex[d].jl, m_ex[d].jlr});
      chk($sformatf("d%0d.mem", d), {mem_read[d], mem_write[d], mem_f3[d]},
          {m_mem[d].ld, m_mem[d].st, m_mem[d].f3});
      chk($sformatf("d%0d.wb", d), {wb_reg_write[d], wb_sel[d], wb_rd[d]},
          {m_wb[d].regw, m_wb[d].wbsel, m_wb[d].rd});
      chk($sformatf("d%0d.illegal", d), illegal[d], m_ex[d].ill);
      stall_cnt[d] += int'(stall_if[d] === 1'b1);
      flush_cnt[d] += int'(flush_id[d] === 1'b1);
      ill_cnt[d]   += int'(illegal[d] === 1'b1);
      wbw_cnt[d]   += int'(wb_reg_write[d] === 1'b1);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_wb[d]  = m_mem[d];
      m_mem[d] = m_ex[d];
      m_ex[d]  = (haz[d] || cur[d].redir) ? '0 : idr[d];
      adv[d]   = !(haz[d] && !cur[d].redir);
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) apply(d);
    #3;
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d.reset_outputs", d), all_out(d), 32'h0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add x3,x1,x2 reaches WB after three edges
    push(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 1'b0));
    run(3);
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d.add_wb", d), {wb_reg_write[d], wb_sel[d], wb_rd[d]}, {1'b1, 2'b00, 5'd3});
    run(2);

    // lw x5 then dependent add
    clr_cnt();
    push(mk(7'h03, 5'd5, 5'd1, 5'd0, 3'd2, 7'h00, 1'b0));
    push(mk(7'h33, 5'd6, 5'd5, 5'd1, 3'd0, 7'h00, 1'b0));
    run(7);
    chk("d0.load_use_stalls", stall_cnt[0], 1);
    chk("d1.raw_stalls_lw", stall_cnt[1], 2);

    // add x7 then sub x8,x7,x7
    clr_cnt();
    push(mk(7'h33, 5'd7, 5'd1, 5'd2, 3'd0, 7'h00, 1'b0));
    push(mk(7'h33, 5'd8, 5'd7, 5'd7, 3'd0, 7'h20, 1'b0));
    run(7);
    chk("d0.add_sub_stalls", stall_cnt[0], 0);
    chk("d1.add_sub_stalls", stall_cnt[1], 2);

    // redirect while the load-dependent add sits in ID
    clr_cnt();
    push(mk(7'h03, 5'd5, 5'd1, 5'd0, 3'd2, 7'h00, 1'b0));
    push(mk(7'h33, 5'd6, 5'd5, 5'd1, 3'd0, 7'h00, 1'b1));
    run(6);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d.redirect_stalls", d), stall_cnt[d], 0);
      chk($sformatf("d%0d.redirect_flushes", d), flush_cnt[d], 1);
    end

    // addi x9: legal only on the full instance
    clr_cnt();
    push(mk(7'h13, 5'd9, 5'd1, 5'd0, 3'd0, 7'h00, 1'b0));
    run(5);
    chk("d0.addi_illegal", ill_cnt[0], 0);
    chk("d1.addi_illegal", ill_cnt[1], 1);
    chk("d0.addi_writes", wbw_cnt[0], 1);
    chk("d1.addi_writes", wbw_cnt[1], 0);

    rand_mode = 1'b1;
    run(400);
    rand_mode = 1'b0;
    run(5);

    // reset with jal in MEM
    push(mk(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 1'b0));
    push(mk(7'h33, 5'd2, 5'd1, 5'd1, 3'd0, 7'h00, 1'b0));
    run(2);
    rst_n = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) apply(d);
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d.midreset_outputs", d), all_out(d), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt();
    run(5);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d.post_reset_writes", d), wbw_cnt[d], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
